// File: rtl/icache_pkg.sv
// Shared types and AXI constants for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MMU  = 2'd1,
    REQ  = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [2:0] SIZE_4B     = 3'b010;

endpackage

// File: rtl/icache_victim_sel.sv
// Victim way picker: lowest-numbered invalid way, else the set's round-robin pointer.
module icache_victim_sel
  import icache_pkg::*;
#(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned WAY_W = 1
) (
  input  logic [WAYS-1:0]  valid_i,
  input  logic [WAY_W-1:0] rr_i,
  output logic [WAY_W-1:0] victim_o
);

  logic found;

  always_comb begin
    victim_o = rr_i;
    found    = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!valid_i[w] && !found) begin
        victim_o = WAY_W'(w);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: combinational lookup, MMU translate on miss,
// critical-word-first WRAP refill into a victim way, fence.i-safe flush.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int unsigned OFFSET_W = 4,
  parameter int unsigned INDEX_W  = 2,
  parameter int unsigned WAYS     = 2,
  parameter int unsigned TAG_W    = 32 - OFFSET_W - INDEX_W
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush_icache,
  input  logic [31:0] addr,
  output logic        hit,
  output logic [31:0] inst,
  output logic        mmu_valid,
  output logic [31:0] mmu_vaddr,
  input  logic        mmu_hit,
  input  logic [31:0] mmu_paddr,
  output logic        mem_r_arvalid,
  input  logic        mem_r_arready,
  output logic [31:0] mem_r_araddr,
  output logic [3:0]  mem_r_arid,
  output logic [7:0]  mem_r_arlen,
  output logic [2:0]  mem_r_arsize,
  output logic [1:0]  mem_r_arburst,
  input  logic        mem_r_rvalid,
  output logic        mem_r_rready,
  input  logic [31:0] mem_r_rdata,
  input  logic [1:0]  mem_r_rresp,
  input  logic        mem_r_rlast,
  output logic        mem_r_awvalid,
  output logic [31:0] mem_r_awaddr,
  output logic        mem_r_wvalid,
  output logic [31:0] mem_r_wdata,
  output logic [3:0]  mem_r_wstrb,
  output logic        mem_r_wlast,
  output logic        mem_r_bready
);

  localparam int unsigned BLOCK_SZ = 1 << (OFFSET_W - 2);
  localparam int unsigned WORD_W   = (OFFSET_W > 2) ? OFFSET_W - 2 : 1;
  localparam int unsigned WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned NSETS    = 1 << INDEX_W;
  localparam logic [WORD_W-1:0] WORD_MASK = WORD_W'(BLOCK_SZ - 1);

  logic [31:0]      data_q  [NSETS][WAYS][BLOCK_SZ];
  logic [TAG_W-1:0] tag_q   [NSETS][WAYS];
  logic [WAYS-1:0]  valid_q [NSETS];
  logic [WAY_W-1:0] rr_q    [NSETS];

  state_t            state_q, state_d;
  logic [TAG_W-1:0]  ltag_q;
  logic [INDEX_W-1:0] lindex_q;
  logic [WORD_W-1:0] lword_q;
  logic [WORD_W-1:0] fill_ptr_q;
  logic [WAY_W-1:0]  vway_q;
  logic [31:0]       paddr_q;
  logic              drop_q;

  logic [TAG_W-1:0]   a_tag;
  logic [INDEX_W-1:0] a_index;
  logic [WORD_W-1:0]  a_word;
  logic [WAY_W-1:0]   hit_way;
  logic [WAY_W-1:0]   victim;
  logic               rbeat;
  logic               last_beat;
  logic               commit;
  logic [WAY_W-1:0]   rr_next;

  assign a_tag   = addr[31 -: TAG_W];
  assign a_index = addr[OFFSET_W +: INDEX_W];
  assign a_word  = WORD_W'((addr >> 2) & 32'(BLOCK_SZ - 1));

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[a_index][w] && (tag_q[a_index][w] == a_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign inst = data_q[a_index][hit_way][a_word];

  icache_victim_sel #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_victim_sel (
    .valid_i  (valid_q[a_index]),
    .rr_i     (rr_q[a_index]),
    .victim_o (victim)
  );

  always_comb begin
    state_d       = state_q;
    mmu_valid     = 1'b0;
    mem_r_arvalid = 1'b0;
    mem_r_rready  = 1'b0;
    unique case (state_q)
      IDLE: if (!hit) state_d = MMU;
      MMU: begin
        mmu_valid = 1'b1;
        if (mmu_hit) state_d = REQ;
      end
      REQ: begin
        mem_r_arvalid = 1'b1;
        if (mem_r_arready) state_d = RESP;
      end
      RESP: begin
        mem_r_rready = 1'b1;
        if (mem_r_rvalid && mem_r_rlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rbeat     = (state_q == RESP) && mem_r_rvalid;
  assign last_beat = rbeat && mem_r_rlast;
  assign commit    = last_beat && !drop_q;
  assign rr_next   = (WAYS > 1) ? rr_q[lindex_q] + 1'b1 : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      drop_q     <= 1'b0;
      fill_ptr_q <= '0;
      ltag_q     <= '0;
      lindex_q   <= '0;
      lword_q    <= '0;
      vway_q     <= '0;
      paddr_q    <= '0;
      for (int unsigned s = 0; s < NSETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && !hit) begin
        ltag_q   <= a_tag;
        lindex_q <= a_index;
        lword_q  <= a_word;
        vway_q   <= victim;
      end
      if (state_q == MMU && mmu_hit) paddr_q <= mmu_paddr;
      if (state_q == REQ && mem_r_arready) fill_ptr_q <= lword_q;
      if (rbeat) fill_ptr_q <= (fill_ptr_q + 1'b1) & WORD_MASK;
      if (flush_icache && state_q != IDLE) drop_q <= 1'b1;
      if (last_beat) drop_q <= 1'b0;
      // Flush first, then commit: a line finishing in the flush cycle survives.
      if (flush_icache) begin
        for (int unsigned s = 0; s < NSETS; s++) valid_q[s] <= '0;
      end
      if (commit) begin
        valid_q[lindex_q][vway_q] <= 1'b1;
        rr_q[lindex_q]            <= rr_next;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rbeat) data_q[lindex_q][vway_q][fill_ptr_q] <= mem_r_rdata;
    if (commit) tag_q[lindex_q][vway_q] <= ltag_q;
  end

  assign mmu_vaddr     = {ltag_q, lindex_q, {OFFSET_W{1'b0}}} | (32'(lword_q) << 2);
  assign mem_r_araddr  = paddr_q;
  assign mem_r_arid    = '0;
  assign mem_r_arlen   = 8'(BLOCK_SZ - 1);
  assign mem_r_arsize  = SIZE_4B;
  assign mem_r_arburst = (BLOCK_SZ > 1) ? BURST_WRAP : BURST_FIXED;

  assign mem_r_awvalid = 1'b0;
  assign mem_r_awaddr  = '0;
  assign mem_r_wvalid  = 1'b0;
  assign mem_r_wdata   = '0;
  assign mem_r_wstrb   = '0;
  assign mem_r_wlast   = 1'b0;
  assign mem_r_bready  = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{mem_r_rresp, addr[1:0]};

`ifndef SYNTHESIS
  logic [1:0]  perf_event;
  logic [31:0] perf_miss_q, perf_busy_q;
  logic        unused_perf;

  assign perf_event = {(state_q == IDLE) && !hit, state_q != IDLE};

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_miss_q <= '0;
      perf_busy_q <= '0;
    end else begin
      if (perf_event[1]) perf_miss_q <= perf_miss_q + 1'b1;
      if (perf_event[0]) perf_busy_q <= perf_busy_q + 1'b1;
    end
  end

  assign unused_perf = ^{perf_miss_q, perf_busy_q};
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: identity MMU and a WRAP-burst AXI read slave
// whose data word is {addr[15:0], 16'hC0DE}.
module tb_icache_assoc;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush_icache = 1'b0;
  logic [31:0] addr = 32'h8000_0008;
  logic        hit;
  logic [31:0] inst;
  logic        mmu_valid;
  logic [31:0] mmu_vaddr;
  logic        mmu_hit = 1'b0;
  logic [31:0] mmu_paddr = '0;
  logic        mem_r_arvalid;
  logic        mem_r_arready = 1'b0;
  logic [31:0] mem_r_araddr;
  logic [3:0]  mem_r_arid;
  logic [7:0]  mem_r_arlen;
  logic [2:0]  mem_r_arsize;
  logic [1:0]  mem_r_arburst;
  logic        mem_r_rvalid = 1'b0;
  logic        mem_r_rready;
  logic [31:0] mem_r_rdata = '0;
  logic [1:0]  mem_r_rresp = 2'b00;
  logic        mem_r_rlast = 1'b0;
  logic        mem_r_awvalid;
  logic [31:0] mem_r_awaddr;
  logic        mem_r_wvalid;
  logic [31:0] mem_r_wdata;
  logic [3:0]  mem_r_wstrb;
  logic        mem_r_wlast;
  logic        mem_r_bready;

  icache_assoc #(.OFFSET_W(4), .INDEX_W(2), .WAYS(2)) dut (
    .clock(clock), .reset(reset), .flush_icache(flush_icache), .addr(addr),
    .hit(hit), .inst(inst), .mmu_valid(mmu_valid), .mmu_vaddr(mmu_vaddr),
    .mmu_hit(mmu_hit), .mmu_paddr(mmu_paddr),
    .mem_r_arvalid(mem_r_arvalid), .mem_r_arready(mem_r_arready), .mem_r_araddr(mem_r_araddr),
    .mem_r_arid(mem_r_arid), .mem_r_arlen(mem_r_arlen), .mem_r_arsize(mem_r_arsize),
    .mem_r_arburst(mem_r_arburst), .mem_r_rvalid(mem_r_rvalid), .mem_r_rready(mem_r_rready),
    .mem_r_rdata(mem_r_rdata), .mem_r_rresp(mem_r_rresp), .mem_r_rlast(mem_r_rlast),
    .mem_r_awvalid(mem_r_awvalid), .mem_r_awaddr(mem_r_awaddr), .mem_r_wvalid(mem_r_wvalid),
    .mem_r_wdata(mem_r_wdata), .mem_r_wstrb(mem_r_wstrb), .mem_r_wlast(mem_r_wlast),
    .mem_r_bready(mem_r_bready)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int mmu_delay = 0, ar_delay = 0;
  int mmu_cnt = 0, ar_cnt = 0, beats_left = 0, beats_done = 0;
  logic [31:0] cur_addr = '0, cap_araddr = '0, cap_vaddr = '0;
  logic [7:0]  cap_arlen = '0;
  logic [1:0]  cap_arburst = '0;
  logic [2:0]  cap_arsize = '0;

  // Responders update 1 time unit after each rising edge.
  always @(posedge clock) begin
    #1;
    if (reset) begin
      mmu_hit = 1'b0; mem_r_arready = 1'b0; mem_r_rvalid = 1'b0; mem_r_rlast = 1'b0;
      beats_left = 0; mmu_cnt = 0; ar_cnt = 0;
    end else begin
      if (mem_r_rvalid) begin
        beats_left--;
        beats_done++;
        cur_addr = {cur_addr[31:4], cur_addr[3:0] + 4'd4};
      end
      if (mem_r_arready) begin
        cur_addr   = cap_araddr;
        beats_left = int'(cap_arlen) + 1;
      end
      if (mmu_valid) begin
        if (mmu_cnt < mmu_delay) begin
          mmu_hit = 1'b0; mmu_cnt++;
        end else begin
          mmu_hit = 1'b1; mmu_paddr = mmu_vaddr; cap_vaddr = mmu_vaddr; mmu_cnt = 0;
        end
      end else begin
        mmu_hit = 1'b0; mmu_cnt = 0;
      end
      if (mem_r_arvalid) begin
        if (ar_cnt < ar_delay) begin
          mem_r_arready = 1'b0; ar_cnt++;
        end else begin
          mem_r_arready = 1'b1; ar_cnt = 0;
          cap_araddr = mem_r_araddr; cap_arlen = mem_r_arlen;
          cap_arburst = mem_r_arburst; cap_arsize = mem_r_arsize;
        end
      end else begin
        mem_r_arready = 1'b0; ar_cnt = 0;
      end
      mem_r_rvalid = (beats_left > 0);
      mem_r_rdata  = {cur_addr[15:0], 16'hC0DE};
      mem_r_rlast  = (beats_left == 1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_hit(input string tag, output int cycles);
    cycles = 0;
    do begin
      @(negedge clock);
      cycles++;
    end while (!hit && cycles < 200);
    chk(tag, 32'(hit), 32'd1);
  endtask

  task automatic wait_rready(input logic lvl, input string tag);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (mem_r_rready !== lvl && n < 200);
    chk(tag, 32'(mem_r_rready), 32'(lvl));
  endtask

  task automatic probe_hit(input logic [31:0] a, input logic [31:0] exp_inst, input string tag);
    addr = a;
    #1;
    chk({tag, "_hit"}, 32'(hit), 32'd1);
    chk({tag, "_inst"}, inst, exp_inst);
  endtask

  task automatic probe_miss(input logic [31:0] a, input string tag);
    addr = a;
    #1;
    chk(tag, 32'(hit), 32'd0);
  endtask

  initial begin
    int cyc;
    int b0, nm, na;
    logic seen;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_mmu_valid", 32'(mmu_valid), 32'd0);
    chk("rst_arvalid", 32'(mem_r_arvalid), 32'd0);
    chk("rst_rready", 32'(mem_r_rready), 32'd0);
    reset = 1'b0;

    // Cold miss at 0x8000_0008: AR fields, minimum penalty, wrapped fill contents
    wait_hit("cold_fill", cyc);
    chk("cold_penalty", 32'(cyc), 32'd7);
    chk("cold_vaddr", cap_vaddr, 32'h8000_0008);
    chk("cold_araddr", cap_araddr, 32'h8000_0008);
    chk("cold_arlen", 32'(cap_arlen), 32'd3);
    chk("cold_arburst", 32'(cap_arburst), 32'd2);
    chk("cold_arsize", 32'(cap_arsize), 32'd2);
    chk("cold_inst8", inst, 32'h0008_C0DE);
    probe_hit(32'h8000_0000, 32'h0000_C0DE, "cold_w0");
    probe_hit(32'h8000_0004, 32'h0004_C0DE, "cold_w1");
    probe_hit(32'h8000_000C, 32'h000C_C0DE, "cold_w3");

    // Conflicts in set 0: invalid-first, then round-robin eviction
    @(negedge clock);
    addr = 32'h8000_0040;
    wait_hit("conf_fill40", cyc);
    chk("conf_penalty40", 32'(cyc), 32'd7);
    addr = 32'h8000_0080;
    wait_hit("conf_fill80", cyc);
    probe_hit(32'h8000_0040, 32'h0040_C0DE, "conf_keep40");
    probe_hit(32'h8000_0080, 32'h0080_C0DE, "conf_new80");
    probe_miss(32'h8000_0000, "conf_evict00");
    addr = 32'h8000_0080;
    @(negedge clock);
    addr = 32'h8000_0000;
    wait_hit("conf_refill00", cyc);
    chk("conf_inst00", inst, 32'h0000_C0DE);
    probe_hit(32'h8000_0080, 32'h0080_C0DE, "rr_keep80");
    probe_miss(32'h8000_0040, "rr_evict40");
    addr = 32'h8000_0000;

    // Four valid lines, then flush while idle
    @(negedge clock);
    addr = 32'h8000_0010;
    wait_hit("fl_fill10", cyc);
    addr = 32'h8000_0020;
    wait_hit("fl_fill20", cyc);
    probe_hit(32'h8000_0000, 32'h0000_C0DE, "fl_pre00");
    probe_hit(32'h8000_0080, 32'h0080_C0DE, "fl_pre80");
    probe_hit(32'h8000_0010, 32'h0010_C0DE, "fl_pre10");
    probe_hit(32'h8000_0020, 32'h0020_C0DE, "fl_pre20");
    @(negedge clock);
    addr = 32'h8000_0000;
    flush_icache = 1'b1;
    @(negedge clock);
    flush_icache = 1'b0;
    chk("fl_post00", 32'(hit), 32'd0);
    probe_miss(32'h8000_0080, "fl_post80");
    probe_miss(32'h8000_0010, "fl_post10");
    probe_miss(32'h8000_0020, "fl_post20");
    addr = 32'h8000_0000;
    wait_hit("fl_refill00", cyc);

    // Flush during RESP beat 1: burst completes, line not validated
    @(negedge clock);
    b0 = beats_done;
    addr = 32'h8000_0030;
    wait_rready(1'b1, "drop_resp");
    @(negedge clock);
    flush_icache = 1'b1;
    @(negedge clock);
    flush_icache = 1'b0;
    wait_rready(1'b0, "drop_done");
    chk("drop_beats", 32'(beats_done - b0), 32'd4);
    chk("drop_invalid", 32'(hit), 32'd0);
    @(negedge clock);
    chk("drop_refetch", 32'(mmu_valid), 32'd1);
    wait_hit("drop_refill", cyc);
    chk("drop_inst", inst, 32'h0030_C0DE);

    // Stalled MMU/AR with addr changing mid-miss
    @(negedge clock);
    mmu_delay = 5;
    ar_delay  = 3;
    addr = 32'h8000_0050;
    nm = 0; na = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (i == 2) addr = 32'h1234_5678;
      if (mmu_valid) begin
        nm++;
        chk("stall_vaddr", mmu_vaddr, 32'h8000_0050);
      end
      if (mem_r_arvalid) begin
        na++;
        chk("stall_araddr", mem_r_araddr, 32'h8000_0050);
      end
      if (mem_r_rready) seen = 1'b1;
      else if (seen) break;
    end
    addr = 32'h8000_0050;
    mmu_delay = 0;
    ar_delay  = 0;
    chk("stall_mmu_cycles", 32'(nm), 32'd6);
    chk("stall_ar_cycles", 32'(na), 32'd4);
    chk("stall_cap_araddr", cap_araddr, 32'h8000_0050);
    probe_hit(32'h8000_0050, 32'h0050_C0DE, "stall_line");

    // Reset mid-RESP, then a clean miss
    @(negedge clock);
    addr = 32'h8000_0060;
    wait_rready(1'b1, "rst_resp");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rstm_arvalid", 32'(mem_r_arvalid), 32'd0);
    chk("rstm_rready", 32'(mem_r_rready), 32'd0);
    chk("rstm_hit60", 32'(hit), 32'd0);
    probe_miss(32'h8000_0050, "rstm_hit50");
    probe_miss(32'h8000_0030, "rstm_hit30");
    addr = 32'h8000_0070;
    @(negedge clock);
    reset = 1'b0;
    wait_hit("rstm_fill70", cyc);
    chk("rstm_penalty", 32'(cyc), 32'd7);
    chk("rstm_inst70", inst, 32'h0070_C0DE);
    chk("rstm_araddr", cap_araddr, 32'h8000_0070);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/icache_assoc.md
# icache_assoc

Parametrised set-associative instruction cache sitting between the IFU fetch address and the AXI read port, successor to the direct-mapped ICache. Lookup is combinational across all ways. A miss translates the line address through the MMU port, then fills the line with a critical-word-first WRAP burst into a victim way. Victims are chosen invalid-first, then per-set round-robin. Flush is fence.i-safe: a flush during a miss invalidates the in-flight fill.

## Interface
- OFFSET_W, 4: log2 block bytes, ≥2; BLOCK_SZ = 2^(OFFSET_W-2) words.
- INDEX_W, 2: log2 set count.
- WAYS, 2: associativity, power of two, ≥1; WAY_W = max(1, log2 WAYS).
- TAG_W, 32-OFFSET_W-INDEX_W: tag width.
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- flush_icache  in  1  invalidate all lines.
- addr  in  32  fetch virtual address, word-aligned.
- hit  out  1  addr present in cache.
- inst  out  32  word at addr from the hitting way; don't-care when hit=0.
- mmu_valid  out  1  translation request.
- mmu_vaddr  out  32  virtual address to translate.
- mmu_hit  in  1  translation done.
- mmu_paddr  in  32  translated address.
- mem_r  axi_if.out  -  AXI read: ar*/r* used; aw/w/b unused, tied 0.

## Operation
- Address split: tag = addr[31:OFFSET_W+INDEX_W], index = next INDEX_W bits, word = addr[OFFSET_W-1:2].
- hit = OR over ways of (valid & tag match). A tag can live in at most one way per set.
- FSM states: IDLE, MMU, REQ, RESP.
  - IDLE → MMU when hit=0. Latch tag, index, word and the victim way in the same cycle.
  - MMU: mmu_valid=1, mmu_vaddr = {ltag, lindex, lword, 2'b00}. On mmu_hit, latch mmu_paddr and go to REQ.
  - REQ: arvalid=1, araddr = latched paddr (critical word), arid=0, arlen=BLOCK_SZ-1, arsize=3'b010, arburst = WRAP (2'b10) when BLOCK_SZ>1, else FIXED (2'b00). On arready go to RESP.
  - RESP: rready=1. Each beat writes data[lindex][vway][fill_ptr], then fill_ptr = (fill_ptr+1) mod BLOCK_SZ. fill_ptr is loaded with lword on the AR handshake. On the rlast beat, set valid and tag for the victim way unless drop=1, then go to IDLE.
- All fill writes use the latched index, tag and way, never the live addr. addr may change during a miss.
- Victim selection:
  - Lowest-numbered invalid way in the set, if any.
  - Otherwise rr[index], the per-set round-robin pointer.
  - rr[index] increments mod WAYS on every committed fill.
- Flush:
  - Clears every valid bit, except a line whose rlast commit happens in the same cycle with drop=0.
  - Flush in MMU, REQ or RESP sets drop. The burst still completes (no AXI abort), but the line is not validated.
  - drop clears on return to IDLE.
- rresp is ignored.
- Reset:
  - State goes to IDLE and all valid bits clear, so hit=0 from the first post-reset cycle.
  - rr, drop and fill_ptr go to 0. mmu_valid, arvalid and rready are 0.
  - Reset mid-burst abandons the transaction; the interconnect is reset alongside.
  - Data and tag arrays are not reset.

## Timing
- Hit: combinational, zero-cycle.
- Miss, with MMU and AXI responding immediately: IDLE detect (1 cycle), MMU (1), REQ (1), then BLOCK_SZ beats. hit asserts the cycle after the rlast beat.
- Minimum miss penalty is 3 + BLOCK_SZ cycles.
- The handshakes are registered-state driven: arvalid, rready and mmu_valid depend on state only, never combinationally on ready/valid inputs.
- arvalid stays high until arready, with araddr stable.
- A pending hit in IDLE never triggers a request.

## Structure
- Shared package icache_pkg holds:
  - the state_t enum (IDLE, MMU, REQ, RESP);
  - AXI constants BURST_FIXED=2'b00, BURST_WRAP=2'b10, SIZE_4B=3'b010.
- One sub-module, icache_victim_sel: takes the set's valid vector and rr pointer, returns the victim way. It is purely combinational; the rr storage stays in the top module.
- Perf hooks (miss count, busy cycles) sit under `ifndef SYNTHESIS` via perf_event.

## Test plan
- Cold miss, WAYS=2, OFFSET_W=4, addr=0x8000_0008:
  - AR has araddr=0x8000_0008, arlen=3, arburst=2'b10;
  - beats land at words 2,3,0,1;
  - afterwards hit=1 for 0x8000_0000..0x8000_000C with the correct inst.
- Conflict, INDEX_W=2:
  - fetch 0x8000_0000, then 0x8000_0040, then 0x8000_0080;
  - the first two fill ways 0 and 1;
  - the third evicts way 0 (rr), so 0x8000_0000 misses and 0x8000_0040 still hits.
- flush_icache in IDLE with 4 valid lines → all hits drop the next cycle.
- flush_icache asserted during RESP beat 1:
  - the burst completes;
  - the line stays invalid and a refetch misses.
- Stalls and address changes:
  - MMU stalls 5 cycles and arready stalls 3 cycles;
  - addr changes mid-miss;
  - the fill still targets the originally latched index, tag and paddr, and mmu_vaddr/araddr stay stable.
- Reset mid-RESP:
  - afterwards hit=0 everywhere, arvalid=0 and rready=0;
  - a new miss proceeds normally.
